// File: rtl/spi_load_pkg.sv
// spi_load_pkg: command byte codes and FSM state encoding for the SPI boot loader.
package spi_load_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;
  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM_HI,
    S_CSUM_LO,
    S_IGNORE
  } state_t;
endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: oversampled SPI mode-0 receiver; emits one-cycle byte strobes framed by ncs.
module spi_byte_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck_i,
  input  logic       ncs_i,
  input  logic       mosi_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       cs_active_o
);
  logic [1:0] sck_sync_q, ncs_sync_q, mosi_sync_q;
  logic       sck_prev_q, blk_q, valid_q;
  logic [2:0] cnt_q;
  logic [7:0] shift_q;
  logic       sck_s, ncs_s, mosi_s, rise, cs;
  assign sck_s  = sck_sync_q[1];
  assign ncs_s  = ncs_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign rise   = sck_s & ~sck_prev_q;
  // blk_q masks a frame already in progress when reset releases until ncs is seen high
  assign cs     = ~ncs_s & ~blk_q;
  always_ff @(posedge clk) begin
    sck_sync_q  <= {sck_sync_q[0], sck_i};
    ncs_sync_q  <= {ncs_sync_q[0], ncs_i};
    mosi_sync_q <= {mosi_sync_q[0], mosi_i};
    sck_prev_q  <= sck_s;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q   <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      blk_q   <= blk_q & ~ncs_s;
      valid_q <= cs & rise & (cnt_q == 3'd7);
      if (!cs) cnt_q <= '0;
      else if (rise) begin
        cnt_q   <= cnt_q + 3'd1;
        shift_q <= {shift_q[6:0], mosi_s};
      end
    end
  end
  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign cs_active_o  = cs;
endmodule

// File: rtl/spi_load_ctrl.sv
// spi_load_ctrl: SPI command decoder writing CPU program memory; LOADER_CHECKSUM_EN gates RUN on a checksum.
module spi_load_ctrl
  import spi_load_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              ncs,
  input  logic              mosi,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              load_busy,
  output logic              load_error
);
  logic [7:0]        rx_byte;
  logic              rx_valid, cs_active;
  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d, cr_q, cr_d, err_q, err_d;
  logic [15:0]       word;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif
  spi_byte_rx u_rx (
    .clk          (clk),
    .reset        (reset),
    .sck_i        (sck),
    .ncs_i        (ncs),
    .mosi_i       (mosi),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .cs_active_o  (cs_active)
  );
  assign word = {hi_q, rx_byte};
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    addr_d  = we_q ? addr_q + ADDR_W'(1) : addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    cr_d    = cr_q;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = we_q ? sum_q + wdata_q : sum_q;
`endif
    if (!cs_active) state_d = S_IDLE;
    else if (state_q == S_IDLE) state_d = S_CMD;
    else if (rx_valid) begin
      case (state_q)
        S_CMD: begin
          if (rx_byte == CMD_WRITE) begin
            cr_d    = 1'b1;
            err_d   = 1'b0;
            state_d = S_ADDR_HI;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else if (rx_byte == CMD_RUN) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM_HI;
`else
            cr_d    = 1'b0;
            state_d = S_IGNORE;
`endif
          end else if (rx_byte == CMD_HALT) begin
            cr_d    = 1'b1;
            state_d = S_IGNORE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IGNORE;
          end
        end
        S_ADDR_HI: begin
          hi_d    = rx_byte;
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d  = word[ADDR_W-1:0];
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = rx_byte;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          wdata_d = word;
          we_d    = 1'b1;
          state_d = S_DATA_HI;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM_HI: begin
          hi_d    = rx_byte;
          state_d = S_CSUM_LO;
        end
        S_CSUM_LO: begin
          cr_d    = (word == sum_q) ? 1'b0 : cr_q;
          err_d   = (word == sum_q) ? err_q : 1'b1;
          state_d = S_IGNORE;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cr_q    <= 1'b1;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cr_q    <= cr_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_reset  = cr_q;
  assign load_error = err_q;
  assign load_busy  = cs_active;
endmodule

// File: tb/tb_spi_load_ctrl.sv
// tb_spi_load_ctrl: directed plus random SPI frames scored against a frame-level loader model.
module tb_spi_load_ctrl;
  localparam int ADDR_W = 11;
  localparam int HC = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0, ncs = 1'b1, mosi = 1'b0;
  logic mem_we, cpu_reset, load_busy, load_error;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0] mem_wdata;
  int n_chk = 0, n_fail = 0;
  logic [7:0] frm[$];
  logic [31:0] expq[$];
  logic mcr = 1'b1, merr = 1'b0, prev_we = 1'b0;
  logic [15:0] msum = '0;
  spi_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .ncs        (ncs),
    .mosi       (mosi),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .load_busy  (load_busy),
    .load_error (load_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_we) begin
      chk("we_1clk", 32'(prev_we), 32'd0);
      chk("we_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        logic [31:0] e;
        e = expq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[26:16]));
        chk("wr_data", 32'(mem_wdata), 32'(e[15:0]));
      end
    end
    prev_we = mem_we;
  end
  // Frame-level semantics: what a complete list of received bytes means to the loader.
  task automatic model_frame();
    int n;
    logic [ADDR_W-1:0] a;
    logic [15:0] w;
    n = frm.size();
    if (n == 0) return;
    case (frm[0])
      8'h01: begin
        mcr = 1'b1;
        merr = 1'b0;
        msum = '0;
        if (n >= 3) begin
          w = {frm[1], frm[2]};
          a = w[ADDR_W-1:0];
          for (int k = 3; k + 1 < n; k += 2) begin
            w = {frm[k], frm[k+1]};
            expq.push_back({5'd0, a, w});
            msum = msum + w;
            a = a + 1'b1;
          end
        end
      end
      8'h02: begin
`ifdef LOADER_CHECKSUM_EN
        if (n >= 3) begin
          if ({frm[1], frm[2]} == msum) mcr = 1'b0;
          else merr = 1'b1;
        end
`else
        mcr = 1'b0;
`endif
      end
      8'h03: mcr = 1'b1;
      default: merr = 1'b1;
    endcase
  endtask
  task automatic spi_bits(input logic [7:0] b, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = b[i];
      repeat (HC) @(negedge clk);
      sck = 1'b1;
      repeat (HC) @(negedge clk);
      sck = 1'b0;
    end
  endtask
  task automatic run_frame(input string tag);
    model_frame();
    ncs = 1'b0;
    repeat (5) @(negedge clk);
    chk({tag, "_busy"}, 32'(load_busy), 32'd1);
    foreach (frm[i]) spi_bits(frm[i], 8);
    repeat (HC) @(negedge clk);
    ncs = 1'b1;
    repeat (6) @(negedge clk);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(mcr));
    chk({tag, "_error"}, 32'(load_error), 32'(merr));
    chk({tag, "_idle"}, 32'(load_busy), 32'd0);
  endtask
  initial begin
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    frm = '{8'h01, 8'h00, 8'h10, 8'hAB, 8'hCD, 8'h12, 8'h34};
    run_frame("write2");
    frm = '{8'h02, msum[15:8], msum[7:0]};
    run_frame("run_good");
    frm = '{8'h01, 8'h07, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("wrap");
    frm = '{8'h02, 8'h00, 8'h00};
    run_frame("run_bad");
    frm = '{8'h03};
    run_frame("halt");
    frm = '{8'h01, 8'h00, 8'h00, 8'hAA};
    run_frame("trunc");
    frm = '{8'h02};
    run_frame("run_short");
    frm = '{8'h7F};
    run_frame("badcmd");
    ncs = 1'b0;
    repeat (5) @(negedge clk);
    spi_bits(8'hA5, 3);
    ncs = 1'b1;
    repeat (6) @(negedge clk);
    frm = '{8'h03};
    run_frame("halt_after_partial");
    ncs = 1'b0;
    repeat (5) @(negedge clk);
    spi_bits(8'h01, 8);
    spi_bits(8'h00, 8);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mcr = 1'b1;
    merr = 1'b0;
    msum = '0;
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_wdata", 32'(mem_wdata), 32'd0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_busy", 32'(load_busy), 32'd0);
    spi_bits(8'h00, 8);
    spi_bits(8'hAA, 8);
    spi_bits(8'hBB, 8);
    chk("midrst_busy2", 32'(load_busy), 32'd0);
    repeat (HC) @(negedge clk);
    ncs = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_error", 32'(load_error), 32'(merr));
    for (int t = 0; t < 24; t++) begin
      int r;
      r = $urandom_range(0, 5);
      frm.delete();
      if (r <= 1) begin
        frm.push_back(8'h01);
        frm.push_back(8'($urandom_range(0, 255)));
        frm.push_back(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 3)) begin
          frm.push_back(8'($urandom_range(0, 255)));
          frm.push_back(8'($urandom_range(0, 255)));
        end
        if ($urandom_range(0, 2) == 0) frm.push_back(8'($urandom_range(0, 255)));
      end else if (r == 2) frm = '{8'h02, msum[15:8], msum[7:0]};
      else if (r == 3) frm = '{8'h02, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      else if (r == 4) frm = '{8'h03, 8'($urandom_range(0, 255))};
      else frm = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      run_frame("rand");
    end
    repeat (10) @(negedge clk);
    chk("pending_writes", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
